gs_prefetch_buffer: RTL

Parametrised instruction prefetch buffer between the fetch stage and instruction memory. It issues sequential word reads ahead of the core and buffers up to DEPTH returned instructions with their addresses. On a redirect it flushes the buffer and discards any stale in-flight responses. It supersedes the single-entry prefetch controller and adds multiple outstanding requests, a request/grant memory handshake and redirect flushing.

---
 rtl/gs_prefetch_buffer_if.sv | 23 ++
 rtl/gs_prefetch_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gs_prefetch_buffer_if.sv
// Instruction-memory request/grant bus used by gs_prefetch_buffer.
// master: the prefetch buffer (issues requests). slave: the instruction memory.
interface gs_prefetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              im_req_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [3:0]        im_web_o;
  logic              im_gnt_i;
  logic              im_rvalid_i;
  logic [DATA_W-1:0] im_rdata_i;

  modport master (
    output im_req_o, im_addr_o, im_web_o,
    input  im_gnt_i, im_rvalid_i, im_rdata_i
  );

  modport slave (
    input  im_req_o, im_addr_o, im_web_o,
    output im_gnt_i, im_rvalid_i, im_rdata_i
  );
endinterface

// File: rtl/gs_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word reads ahead of the core,
// keeps up to DEPTH returned instructions with their addresses, and flushes on
// redirect while draining stale in-flight responses.
// Optional feature macro: GS_PF_BYPASS_EN (empty-FIFO combinational bypass of
// the returning read data to the instruction outputs).
module gs_prefetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_addr_i,
  output logic                instr_valid_o,
  output logic [DATA_W-1:0]   instr_o,
  output logic [ADDR_W-1:0]   instr_addr_o,
  input  logic                instr_ready_i,
  output logic                pf_fetching_o,
  output logic                pf_ready_o,
  gs_prefetch_buffer_if.master im
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ~(STRIDE - ADDR_W'(1));
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, raddr_q;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d, fifo_cnt_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic              grant, rsp, accept, push, pop, fifo_empty, credit;

  assign fifo_empty = (fifo_cnt_q == '0);
  // Credits cover both buffered and in-flight words so a push never meets a full FIFO.
  assign credit = ({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < SUM_W'(DEPTH);
  assign grant  = im.im_req_o && im.im_gnt_i;
  // Any response outside IDLE retires an outstanding request, kept or not.
  assign rsp    = im.im_rvalid_i && (state_q != IDLE);
  // Only responses in RUN without a concurrent redirect belong to the live stream.
  assign accept = im.im_rvalid_i && (state_q == RUN) && !redirect_i;
  assign pop    = !fifo_empty && instr_ready_i;
  assign pf_fetching_o = im.im_req_o || (out_cnt_q != '0);
  assign pf_ready_o    = (state_q == RUN);

  // Outstanding-request count for the next cycle; a stale grant still counts.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (state_q == IDLE) out_cnt_d = '0;
    else                 out_cnt_d = out_cnt_q + CNT_W'(grant) - CNT_W'(rsp);
  end

  // FSM state register plus all control counters and pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      raddr_q    <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      if (redirect_i) begin
        pc_q       <= align_addr(redirect_addr_i);
        raddr_q    <= align_addr(redirect_addr_i);
        fifo_cnt_q <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (grant)  pc_q    <= pc_q + STRIDE;
        if (accept) raddr_q <= raddr_q + STRIDE;
        if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage; data only, no reset needed since validity lives in fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= im.im_rdata_i;
      fifo_addr[wr_ptr_q]  <= raddr_q;
    end
  end

  // FSM next state: redirect in RUN drains only if stale requests remain in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (redirect_i) state_d = RUN;
      RUN:     if (redirect_i && (out_cnt_d != '0)) state_d = DRAIN;
      DRAIN:   if (!redirect_i && (out_cnt_d == '0)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request depends only on state and credits, never on the grant.
  always_comb begin
    im.im_req_o  = (state_q == RUN) && credit;
    im.im_addr_o = pc_q;
    im.im_web_o  = 4'hF;
  end

`ifdef GS_PF_BYPASS_EN
  // Head of FIFO, or the returning word directly when the FIFO is empty.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_addr_o  = '0;
    push          = accept;
    if (!fifo_empty) begin
      instr_valid_o = 1'b1;
      instr_o       = fifo_instr[rd_ptr_q];
      instr_addr_o  = fifo_addr[rd_ptr_q];
    end else if (accept) begin
      instr_valid_o = 1'b1;
      instr_o       = im.im_rdata_i;
      instr_addr_o  = raddr_q;
      if (instr_ready_i) push = 1'b0;
    end
  end
`else
  // Head of FIFO; outputs read zero while empty.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_addr_o  = '0;
    push          = accept;
    if (!fifo_empty) begin
      instr_valid_o = 1'b1;
      instr_o       = fifo_instr[rd_ptr_q];
      instr_addr_o  = fifo_addr[rd_ptr_q];
    end
  end
`endif
endmodule
